// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults, also imported by the scheduler.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned FQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        StFetch,
        StFull,
        StHalted
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} pairs; flush wins over push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = FQ_DEPTH_DEFAULT,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            push_i,
    input  fetch_entry_t    push_data_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output fetch_entry_t    head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

    // Pops on empty are dropped; a push on full is only taken alongside a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PtrW'(1);
            if (do_pop)  rptr_d = rptr_q + PtrW'(1);
            if (do_push && !do_pop) count_d = count_q + CntW'(1);
            if (do_pop && !do_push) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (do_push && !flush_i) mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register and fetch FSM feeding a fetch queue toward the scheduler.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic        CLK,
    input  logic        nRST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned CntW = $clog2(FQ_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            push, pop;
    logic            q_full, q_empty;
    logic [CntW-1:0] count, count_d;
    fetch_entry_t    head, push_entry;

    fetch_queue #(
        .Depth (FQ_DEPTH)
    ) u_queue (
        .CLK         (CLK),
        .nRST        (nRST),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (count)
    );

    assign imemaddr    = {pc_q[31:2], 2'b00};
    assign instr_valid = ~q_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    // A redirect kills the same-cycle fill and pop, so the stale word never lands.
    always_comb begin
        push             = imemREN & ihit & ~redirect_valid;
        pop              = instr_valid & instr_ready & ~redirect_valid;
        push_entry.pc    = imemaddr;
        push_entry.instr = imemload;
        count_d          = count;
        if (redirect_valid) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count + CntW'(1);
        end else if (pop && !push) begin
            count_d = count - CntW'(1);
        end
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_d = imemaddr + 32'd4;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = (state_q == StHalted) ? StHalted : StFetch;
        end else if (halt) begin
            state_d = StHalted;
        end else begin
            unique case (state_q)
                StFetch:  if (count_d == CntW'(FQ_DEPTH)) state_d = StFull;
                StFull:   if (count_d != CntW'(FQ_DEPTH)) state_d = StFetch;
                StHalted: state_d = StFetch;
                default:  state_d = StFetch;
            endcase
        end
    end

    always_comb begin
        imemREN = nRST & (state_q == StFetch) & ~q_full & ~halt;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch, stall, miss, redirect, halt and wrap cases.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] Key = 32'hA5A5_0000;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        imemREN2, ihit2, instr_valid2;
    logic [31:0] imemaddr2, imemload2, instr2, instr_pc2;

    int          tests = 0;
    int          failed = 0;
    logic [31:0] exp_pc;
    fetch_entry_t sb[$];

    assign imemload  = imemaddr ^ Key;
    assign imemload2 = imemaddr2 ^ Key;

    fetch_unit dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .imemREN        (imemREN),
        .imemaddr       (imemaddr),
        .ihit           (ihit),
        .imemload       (imemload),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut2 (
        .CLK            (CLK),
        .nRST           (nRST),
        .imemREN        (imemREN2),
        .imemaddr       (imemaddr2),
        .ihit           (ihit2),
        .imemload       (imemload2),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .halt           (1'b0),
        .instr_valid    (instr_valid2),
        .instr          (instr2),
        .instr_pc       (instr_pc2),
        .instr_ready    (1'b1)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected fetch.
    always @(negedge CLK) begin
        if (nRST && instr_valid && instr_ready && !redirect_valid) begin
            if (sb.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_pop: got pc %h, expected empty queue", instr_pc);
            end else begin
                fetch_entry_t e;
                e = sb.pop_front();
                chk("head_pc", instr_pc, e.pc);
                chk("head_instr", instr, e.instr);
            end
        end
    end

    task automatic do_reset();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
        nRST           = 1'b0;
        ihit           = 1'b0;
        instr_ready    = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        chk("rst_imemREN", 32'(imemREN), 32'd0);
        chk("rst_imemaddr", imemaddr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        exp_pc = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // One cycle: drive inputs, check fetch request, predict the push, advance.
    task automatic step(input logic hit, input logic rdy, input logic hlt, input logic rv,
                        input logic [31:0] rpc, input logic exp_ren);
        ihit           = hit;
        instr_ready    = rdy;
        halt           = hlt;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        chk("imemREN", 32'(imemREN), 32'(exp_ren));
        chk("imemaddr", imemaddr, exp_pc);
        if (exp_ren && hit && !rv) begin
            sb.push_back('{pc: exp_pc, instr: exp_pc ^ Key});
            exp_pc = exp_pc + 32'd4;
        end
        if (rv) exp_pc = {rpc[31:2], 2'b00};
        @(posedge CLK);
        if (rv) sb.delete();
        #1;
    endtask

    initial begin
        ihit2 = 1'b0;
        do_reset();

        // Streaming: hit every cycle, scheduler always ready.
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Back-pressure: fill to depth, then one pop allows one refetch.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1);
        chk("full_state", 32'(dut.state_q), 32'(StFull));
        step(1, 0, 0, 0, 0, 0);
        chk("full_valid", 32'(instr_valid), 32'd1);
        step(1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1);

        // Miss: address held at 8 with nothing queued.
        do_reset();
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, 1);
        chk("miss_no_push", 32'(instr_valid), 32'd0);
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Redirect with 3 queued and a same-cycle hit.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 1, 32'h0000_1002, 1);
        chk("redir_flush", 32'(instr_valid), 32'd0);
        step(0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Halt drains the queue, then resumes at the held PC.
        do_reset();
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        chk("halt_drained", 32'(instr_valid), 32'd0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Redirect while halted keeps HALTED but moves the PC.
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 32'h0000_0203, 0);
        chk("halt_redir_state", 32'(dut.state_q), 32'(StHalted));
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Reset in the middle of a miss with an entry queued.
        do_reset();
        step(1, 0, 0, 0, 0, 1);
        ihit = 1'b0;
        #1;
        chk("pre_rst_miss_addr", imemaddr, 32'h4);
        sb.delete();
        do_reset();
        step(1, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);

        // Wrap-around on the second instance.
        ihit2 = 1'b1;
        #1;
        chk("wrap_ren", 32'(imemREN2), 32'd1);
        chk("wrap_addr0", imemaddr2, 32'hFFFF_FFF8);
        @(posedge CLK);
        #1;
        chk("wrap_addr1", imemaddr2, 32'hFFFF_FFFC);
        chk("wrap_head0", instr_pc2, 32'hFFFF_FFF8);
        @(posedge CLK);
        #1;
        chk("wrap_addr2", imemaddr2, 32'h0000_0000);
        chk("wrap_head1", instr_pc2, 32'hFFFF_FFFC);
        chk("wrap_instr1", instr2, 32'hFFFF_FFFC ^ Key);
        ihit2 = 1'b0;

        chk("sb_final", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 4, fetch-queue entries (power of two, >=2).
REQ-003 SHALL have port CLK  input  1  clock, rising-edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imemREN  output  1  instruction read request to icache.
REQ-006 SHALL have port imemaddr  output  32  word-aligned fetch address to icache.
REQ-007 SHALL have port ihit  input  1  icache hit, same cycle as request.
REQ-008 SHALL have port imemload  input  32  instruction word, valid when ihit.
REQ-009 SHALL have port redirect_valid  input  1  branch/jump redirect from resolve stage.
REQ-010 SHALL have port redirect_pc  input  32  redirect target.
REQ-011 SHALL have port halt  input  1  level request to stop issuing fetches.
REQ-012 SHALL have port instr_valid  output  1  queue head valid to scheduler.
REQ-013 SHALL have port instr  output  32  queue head instruction.
REQ-014 SHALL have port instr_pc  output  32  queue head PC.
REQ-015 SHALL have port instr_ready  input  1  scheduler accepts head this cycle.

Function
REQ-016 SHALL implement FSM states FETCH, FULL, HALTED.
REQ-017 FETCH -> FULL when a push makes count==FQ_DEPTH; FULL -> FETCH when count<FQ_DEPTH; any state -> HALTED when halt=1; HALTED -> FETCH when halt=0.
REQ-018 imemREN SHALL be 1 only in FETCH with count<FQ_DEPTH and halt=0; imemaddr SHALL equal PC, {PC[31:2],2'b00}.
REQ-019 imemaddr SHALL stay stable while imemREN=1 and ihit=0 (icache miss), absent redirect.
REQ-020 On imemREN&ihit without redirect: push {PC, imemload}; PC <= PC+4 next cycle, 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-021 Pop SHALL occur when instr_valid&instr_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-022 instr_valid SHALL equal count!=0; instr/instr_pc SHALL be head entry, zero when empty.
REQ-023 redirect_valid SHALL flush queue (count<=0), discard that cycle's ihit and pop, PC <= {redirect_pc[31:2],2'b00}; highest priority over push, pop, halt.
REQ-024 Redirect in HALTED SHALL update PC and flush; state stays HALTED.
REQ-025 Redirect during an outstanding miss: next cycle imemaddr = new PC; stale fill never enters queue.
REQ-026 Queue SHALL never overflow or underflow; pop on empty ignored.
REQ-027 Hit-to-instr_valid latency SHALL be 1 cycle (registered queue).

Reset
REQ-028 On nRST=0: PC=RESET_PC, count=0, read/write pointers=0, state=FETCH, all queue entries 0.
REQ-029 During reset: imemREN=0, imemaddr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-030 Reset asserted mid-miss or mid-redirect SHALL discard all in-flight state; first request after release at RESET_PC.

Structure
REQ-031 fetch_pkg SHALL hold fetch_entry_t {pc[31:0], instr[31:0]}, fetch_state_t, RESET_PC and FQ_DEPTH defaults; shared with scheduler.
REQ-032 Queue SHALL be sub-module fetch_queue (sync FIFO: push, pop, flush, full, empty, count); PC/FSM stay in fetch_unit.

Verification
REQ-033 Reset, ihit=1 always, instr_ready=1, imemload=addr^32'hA5A5_0000 -> imemaddr 0,4,8,...; instr_pc 0 appears cycle after first hit with matching instr.
REQ-034 instr_ready=0, ihit=1 -> exactly 4 pushes (PC 0..C), imemREN=0, state FULL; one pop -> refetch at 32'h10.
REQ-035 ihit=0 for 5 cycles at PC 32'h8 -> imemaddr held 32'h8, no push; ihit=1 -> push PC 8, then 32'hC.
REQ-036 Queue holds 3, redirect_valid=1 redirect_pc=32'h0000_1002 with ihit=1 -> queue empty next cycle, imemaddr=32'h1000, no push of stale word.
REQ-037 halt=1 with 2 queued, instr_ready=1 -> imemREN=0, 2 pops, instr_valid=0; halt=0 -> resume at held PC.
REQ-038 RESET_PC=32'hFFFF_FFF8, ihit=1 -> imemaddr FFFF_FFF8, FFFF_FFFC, 0000_0000.
